// File: rtl/ram_dp_clr_if.sv
// ram_dp_clr_if: port A read/write, port B read-only and clear/busy signals of ram_dp_clr.
interface ram_dp_clr_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14
);
    logic [DATA_WIDTH-1:0] in;
    logic [DATA_WIDTH-1:0] out;
    logic [DATA_WIDTH-1:0] out_b;
    logic [ADDR_WIDTH-1:0] address;
    logic [ADDR_WIDTH-1:0] address_b;
    logic                  load;
    logic                  clear;
    logic                  busy;
    modport master (output in, address, load, clear, address_b, input out, out_b, busy);
    modport slave  (input in, address, load, clear, address_b, output out, out_b, busy);
endinterface

// File: rtl/ram_dp_clr.sv
// ram_dp_clr: dual-read-port RAM with combinational reads and a one-word-per-clock clear sweep.
// The sweep sequencer exists only when RAM_DP_CLR_SWEEP_EN is defined; otherwise busy is 0.
module ram_dp_clr #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14
) (
    input logic          clk,
    input logic          reset,
    ram_dp_clr_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  we;
    logic [ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0] wd;
    logic                  busy;
`ifdef RAM_DP_CLR_SWEEP_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  busy_q, busy_d;
    logic                  last;
    always_comb begin
        last       = clr_addr_q == ADDR_WIDTH'(DEPTH - 1);
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == CLEAR) begin
            state_d    = last ? IDLE : CLEAR;
            clr_addr_d = last ? clr_addr_q : clr_addr_q + ADDR_WIDTH'(1);
        end else if (bus.clear) begin
            state_d    = CLEAR;
            clr_addr_d = '0;
        end
        busy_d = state_d == CLEAR;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
        end
    end
    // A sweep owns the write port; clear beats a simultaneous load.
    assign busy = busy_q;
    assign we   = !reset && (state_q == CLEAR || (bus.load && !bus.clear));
    assign wa   = state_q == CLEAR ? clr_addr_q : bus.address;
    assign wd   = state_q == CLEAR ? '0 : bus.in;
`else
    logic unused;
    assign unused = ^{reset, bus.clear};
    assign busy   = 1'b0;
    assign we     = bus.load;
    assign wa     = bus.address;
    assign wd     = bus.in;
`endif
    always_ff @(posedge clk) begin
        if (we) mem_q[wa] <= wd;
    end
    assign bus.busy  = busy;
    assign bus.out   = busy ? '0 : mem_q[bus.address];
    assign bus.out_b = busy ? '0 : mem_q[bus.address_b];
endmodule

// File: tb/tb_ram_dp_clr.sv
// tb_ram_dp_clr: vector table, corner sequences and random traffic against an array reference model.
module tb_ram_dp_clr;
    localparam int D4 = 16;
    localparam int D14 = 16384;
    logic clk = 1'b0;
    logic rst4 = 1'b0;
    logic rst14 = 1'b0;
    always #5 clk = ~clk;
    ram_dp_clr_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4))  if4 ();
    ram_dp_clr_if #(.DATA_WIDTH(16), .ADDR_WIDTH(14)) if14 ();
    ram_dp_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(4))  dut4  (.clk(clk), .reset(rst4),  .bus(if4.slave));
    ram_dp_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(14)) dut14 (.clk(clk), .reset(rst14), .bus(if14.slave));
    int n_cmp = 0;
    int n_bad = 0;
    // Reference: word array for both instances (small one first), validity bits, words left to sweep.
    logic [15:0] ref_mem [D4+D14];
    bit          ref_vld [D4+D14];
    int          left [2] = '{0, 0};
    typedef struct {
        bit          ld;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [15:0] d;
        logic [15:0] eo;
        logic [15:0] eob;
    } vec_t;
    vec_t vt [7];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic model_edge(input int k, input logic r, input logic l, input logic c,
                              input int a, input logic [15:0] d);
        int dep;
        int base;
        dep  = k ? D14 : D4;
        base = k ? D4 : 0;
`ifdef RAM_DP_CLR_SWEEP_EN
        if (r) left[k] = dep;
        else if (left[k] > 0) begin
            ref_mem[base + dep - left[k]] = 16'h0;
            ref_vld[base + dep - left[k]] = 1'b1;
            left[k]--;
        end else if (c) left[k] = dep;
        else if (l) begin
            ref_mem[base + a] = d;
            ref_vld[base + a] = 1'b1;
        end
`else
        if (l) begin
            ref_mem[base + a] = d;
            ref_vld[base + a] = 1'b1;
        end
`endif
    endtask
    task automatic check_model(input int k);
        int base, a, b;
        logic bz;
        logic [15:0] o, ob;
        string s;
        base = k ? D4 : 0;
        s    = k ? "14" : "4";
        a    = k ? int'(if14.address) : int'(if4.address);
        b    = k ? int'(if14.address_b) : int'(if4.address_b);
        bz   = k ? if14.busy : if4.busy;
        o    = k ? if14.out : if4.out;
        ob   = k ? if14.out_b : if4.out_b;
        chk({"model_busy", s}, 32'(bz), 32'(left[k] > 0));
        if (left[k] > 0) begin
            chk({"model_out_busy", s}, 32'(o), 32'h0);
            chk({"model_outb_busy", s}, 32'(ob), 32'h0);
        end else begin
            if (ref_vld[base + a]) chk({"model_out", s}, 32'(o), 32'(ref_mem[base + a]));
            if (ref_vld[base + b]) chk({"model_outb", s}, 32'(ob), 32'(ref_mem[base + b]));
        end
    endtask
    task automatic tick();
        @(posedge clk);
        model_edge(0, rst4, if4.load, if4.clear, int'(if4.address), if4.in);
        model_edge(1, rst14, if14.load, if14.clear, int'(if14.address), if14.in);
        #1;
        check_model(0);
        check_model(1);
    endtask
    task automatic count_busy(input int k, output int n);
        n = 0;
        while ((k ? if14.busy : if4.busy) && n < (k ? 20000 : 40)) begin
            tick();
            n++;
        end
    endtask
    task automatic peek4(input int a, input int b, input logic [15:0] eo, input logic [15:0] eob,
                         input string nm);
        if4.address   = 4'(a);
        if4.address_b = 4'(b);
        #1;
        chk({nm, "_out"}, 32'(if4.out), 32'(eo));
        chk({nm, "_outb"}, 32'(if4.out_b), 32'(eob));
    endtask
    initial begin
        int n;
        vt[0] = '{1'b1, 4'd5,  4'd5,  16'hBEEF, 16'hBEEF, 16'hBEEF};
        vt[1] = '{1'b1, 4'd3,  4'd5,  16'h1234, 16'h1234, 16'hBEEF};
        vt[2] = '{1'b0, 4'd3,  4'd3,  16'h0000, 16'h1234, 16'h1234};
        vt[3] = '{1'b0, 4'd0,  4'd15, 16'h0000, 16'h0000, 16'h0000};
        vt[4] = '{1'b1, 4'd15, 4'd15, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vt[5] = '{1'b0, 4'd5,  4'd15, 16'h1111, 16'hBEEF, 16'hFFFF};
        vt[6] = '{1'b1, 4'd0,  4'd5,  16'h0001, 16'h0001, 16'hBEEF};
        {if4.in, if4.address, if4.address_b, if4.load, if4.clear} = '0;
        {if14.in, if14.address, if14.address_b, if14.load, if14.clear} = '0;
        for (int i = 0; i < D4 + D14; i++) ref_vld[i] = 1'b0;
`ifdef RAM_DP_CLR_SWEEP_EN
        rst4  = 1'b1;
        rst14 = 1'b1;
        tick();
        rst4 = 1'b0;
        count_busy(0, n);
        chk("reset_sweep_edges", 32'(n), 32'd16);
        for (int i = 0; i < D4; i++) peek4(i, D4 - 1 - i, 16'h0, 16'h0, "reset_zero");
`else
        rst14    = 1'b1;
        if4.load = 1'b1;
        for (int i = 0; i < D4; i++) begin
            if4.address = 4'(i);
            if4.in      = 16'h0;
            tick();
        end
        if4.load = 1'b0;
`endif
        for (int i = 0; i < 7; i++) begin
            if4.load      = vt[i].ld;
            if4.address   = vt[i].a;
            if4.address_b = vt[i].b;
            if4.in        = vt[i].d;
            tick();
            chk($sformatf("vec%0d_out", i), 32'(if4.out), 32'(vt[i].eo));
            chk($sformatf("vec%0d_outb", i), 32'(if4.out_b), 32'(vt[i].eob));
        end
        if4.load = 1'b0;
        if4.in   = 16'hCAFE;
        peek4(9, 9, 16'h0, 16'h0, "pre_write9");
        if4.load = 1'b1;
        #1;
        chk("no_write_through", 32'(if4.out), 32'h0);
        tick();
        if4.load = 1'b0;
        peek4(9, 9, 16'hCAFE, 16'hCAFE, "post_write9");
        if4.in   = 16'hABCD;
        if4.load = 1'b1;
        peek4(3, 3, 16'h1234, 16'h1234, "pre_write3");
        tick();
        if4.load = 1'b0;
        peek4(3, 3, 16'hABCD, 16'hABCD, "post_write3");
`ifdef RAM_DP_CLR_SWEEP_EN
        if4.load = 1'b1;
        for (int i = 0; i < D4; i++) begin
            if4.address = 4'(i);
            if4.in      = 16'($urandom_range(1, 65535));
            tick();
        end
        if4.address = 4'd7;
        if4.in      = 16'hFFFF;
        if4.clear   = 1'b1;
        tick();
        if4.load  = 1'b0;
        if4.clear = 1'b0;
        chk("clear_busy", 32'(if4.busy), 32'd1);
        peek4(0, 15, 16'h0, 16'h0, "busy_masks");
        count_busy(0, n);
        chk("clear_sweep_edges", 32'(n), 32'd16);
        for (int i = 0; i < D4; i++) peek4(i, i, 16'h0, 16'h0, "clear_zero");
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        repeat (8) tick();
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        chk("restart_busy", 32'(if4.busy), 32'd1);
        count_busy(0, n);
        chk("restart_sweep_edges", 32'(n), 32'd16);
`else
        if4.address = 4'd2;
        if4.in      = 16'hA5A5;
        if4.load    = 1'b1;
        tick();
        if4.load = 1'b0;
        rst4     = 1'b1;
        tick();
        rst4      = 1'b0;
        if4.clear = 1'b1;
        tick();
        if4.clear = 1'b0;
        tick();
        chk("nosweep_busy", 32'(if4.busy), 32'd0);
        chk("nosweep_keep", 32'(if4.out), 32'hA5A5);
        rst4        = 1'b1;
        if4.address = 4'd4;
        if4.in      = 16'h4444;
        if4.load    = 1'b1;
        tick();
        rst4     = 1'b0;
        if4.load = 1'b0;
        chk("write_in_reset", 32'(if4.out), 32'h4444);
`endif
        rst14 = 1'b1;
        tick();
        rst14 = 1'b0;
`ifdef RAM_DP_CLR_SWEEP_EN
        count_busy(1, n);
        chk("big_sweep_edges", 32'(n), 32'd16384);
`endif
        for (int i = 0; i < 16384; i++) begin
            if14.load      = 1'($urandom_range(0, 1));
            if14.address   = $urandom_range(0, 1) ? 14'($urandom_range(0, 63)) : 14'($urandom);
            if14.address_b = $urandom_range(0, 1) ? 14'($urandom_range(0, 63)) : 14'($urandom);
            if14.in        = 16'($urandom);
`ifndef RAM_DP_CLR_SWEEP_EN
            rst14 = $urandom_range(0, 15) == 0;
`endif
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
